regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  A = ALU result, B = load result. Arbitrates each cycle with valid/ready

---
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: A (ALU result) and B (load result). The grant is worked out
//   combinationally from the current-cycle valids, and the winner's Rd/Data
//   are registered onto the write port one cycle later. One accepted write
//   per cycle is sustained.
//
// Parameters
//   DATA_W      write data width
//   ADDR_W      register index width
//   CNT_W       width of the saturating conflict counter
//   FIXED_PRIO  0 = round-robin on conflict, 1 = B always wins on conflict
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   A_Valid/A_Ready/A_Rd/A_Data   ALU writeback handshake and payload
//   B_Valid/B_Ready/B_Rd/B_Data   load writeback handshake and payload
//   RegWrEn/WriteReg/WriteData    registered register-file write request
//   LastGrant                 0 = A granted last, 1 = B granted last
//   ConflictCnt               cycles in which both requesters were valid
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [ADDR_W-1:0] A_Rd,
    input  logic [DATA_W-1:0] A_Data,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [ADDR_W-1:0] B_Rd,
    input  logic [DATA_W-1:0] B_Data,
    output logic              RegWrEn,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              LastGrant,
    output logic [CNT_W-1:0]  ConflictCnt
);

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_favor_a;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;

    // On conflict, A wins only in round-robin mode and only when B had the
    // previous grant. Reset leaves LastGrant=1 so the first conflict goes to A.
    assign w_favor_a  = (FIXED_PRIO != 0) ? 1'b0 : r_last_grant;

    // rst_n gates the grants so neither Ready can rise while reset is held.
    assign w_grant_a  = rst_n & A_Valid & (~B_Valid | w_favor_a);
    assign w_grant_b  = rst_n & B_Valid & ~w_grant_a;
    assign w_grant    = w_grant_a | w_grant_b;
    assign w_conflict = A_Valid & B_Valid;

    assign w_sel_rd   = w_grant_b ? B_Rd   : A_Rd;
    assign w_sel_data = w_grant_b ? B_Data : A_Data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wreg       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            // A write to x0 still completes the handshake but is suppressed here.
            r_wr_en      <= (w_sel_rd != '0);
            r_wreg       <= w_sel_rd;
            r_wdata      <= w_sel_data;
            r_last_grant <= w_grant_b;
        end else begin
            r_wr_en      <= 1'b0;
        end
    end

    // Counts every both-valid cycle regardless of priority mode; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign A_Ready     = w_grant_a;
    assign B_Ready     = w_grant_b;
    assign RegWrEn     = r_wr_en;
    assign WriteReg    = r_wreg;
    assign WriteData   = r_wdata;
    assign LastGrant   = r_last_grant;
    assign ConflictCnt = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected writes into a queue,
// a monitor on the falling edge pops and compares whenever RegWrEn is high.
// Three instances: round-robin (main), FIXED_PRIO=1, and CNT_W=2.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    // round-robin instance
    logic        a_v = 0, b_v = 0;
    logic [4:0]  a_rd = 0, b_rd = 0;
    logic [31:0] a_d = 0, b_d = 0;
    logic        a_r, b_r, wen, lg;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [15:0] cnt;

    regfile_wb_arbiter u_rr (
        .clk(clk), .rst_n(rst_n),
        .A_Valid(a_v), .A_Ready(a_r), .A_Rd(a_rd), .A_Data(a_d),
        .B_Valid(b_v), .B_Ready(b_r), .B_Rd(b_rd), .B_Data(b_d),
        .RegWrEn(wen), .WriteReg(wreg), .WriteData(wdata),
        .LastGrant(lg), .ConflictCnt(cnt)
    );

    // fixed-priority instance
    logic        fa_v = 0, fb_v = 0;
    logic [4:0]  fa_rd = 0, fb_rd = 0;
    logic [31:0] fa_d = 0, fb_d = 0;
    logic        fa_r, fb_r, f_wen, f_lg;
    logic [4:0]  f_wreg;
    logic [31:0] f_wdata;
    logic [15:0] f_cnt;

    regfile_wb_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .A_Valid(fa_v), .A_Ready(fa_r), .A_Rd(fa_rd), .A_Data(fa_d),
        .B_Valid(fb_v), .B_Ready(fb_r), .B_Rd(fb_rd), .B_Data(fb_d),
        .RegWrEn(f_wen), .WriteReg(f_wreg), .WriteData(f_wdata),
        .LastGrant(f_lg), .ConflictCnt(f_cnt)
    );

    // narrow-counter instance
    logic        ca_v = 0, cb_v = 0;
    logic [4:0]  ca_rd = 1, cb_rd = 2;
    logic [31:0] ca_d = 0, cb_d = 0;
    logic        ca_r, cb_r, c_wen, c_lg;
    logic [4:0]  c_wreg;
    logic [31:0] c_wdata;
    logic [1:0]  c_cnt;

    regfile_wb_arbiter #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n),
        .A_Valid(ca_v), .A_Ready(ca_r), .A_Rd(ca_rd), .A_Data(ca_d),
        .B_Valid(cb_v), .B_Ready(cb_r), .B_Rd(cb_rd), .B_Data(cb_d),
        .RegWrEn(c_wen), .WriteReg(c_wreg), .WriteData(c_wdata),
        .LastGrant(c_lg), .ConflictCnt(c_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write presented on the main instance must match the queue head.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got rd=%0d data=0x%0h expected no write", wreg, wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                if (wreg !== e.rd || wdata !== e.data) begin
                    n_err++;
                    $display("FAIL wr_data: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             wreg, wdata, e.rd, e.data);
                end
            end
        end
    end

    // One cycle on the main instance: drive, check Readys mid-cycle against the
    // hand-given grant, queue the expected write, advance past the posedge.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic exp_ar, input logic exp_br, input logic push);
        wr_t e;
        a_v = av; a_rd = ard; a_d = ad;
        b_v = bv; b_rd = brd; b_d = bd;
        @(negedge clk);
        chk("A_Ready", 32'(a_r), 32'(exp_ar));
        chk("B_Ready", 32'(b_r), 32'(exp_br));
        if (push) begin
            if (exp_ar && ard != 0) begin e.rd = ard; e.data = ad; sb_q.push_back(e); end
            if (exp_br && brd != 0) begin e.rd = brd; e.data = bd; sb_q.push_back(e); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state, with both requesters asserting during reset.
        a_v = 1; a_rd = 3; a_d = 32'h33;
        b_v = 1; b_rd = 4; b_d = 32'h44;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_A_Ready", 32'(a_r), 0);
        chk("rst_B_Ready", 32'(b_r), 0);
        chk("rst_RegWrEn", 32'(wen), 0);
        chk("rst_WriteReg", 32'(wreg), 0);
        chk("rst_WriteData", wdata, 0);
        chk("rst_LastGrant", 32'(lg), 1);
        chk("rst_ConflictCnt", 32'(cnt), 0);
        a_v = 0; b_v = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A alone, Rd=5.
        cyc(1, 5, 32'h1234, 0, 0, 0, 1, 0, 1);
        chk("t1_RegWrEn", 32'(wen), 1);
        chk("t1_LastGrant", 32'(lg), 0);

        // B alone to x0: handshake completes, no write.
        cyc(0, 0, 0, 1, 0, 32'hFFFF, 0, 1, 1);
        chk("t4_RegWrEn", 32'(wen), 0);
        chk("t4_LastGrant", 32'(lg), 1);

        // Four conflict cycles, round-robin A,B,A,B; loser holds its request.
        cyc(1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1);
        cyc(1, 3, 32'h33, 1, 2, 32'h22, 0, 1, 1);
        cyc(1, 3, 32'h33, 1, 4, 32'h44, 1, 0, 1);
        cyc(1, 5, 32'h55, 1, 4, 32'h44, 0, 1, 1);
        chk("t2_ConflictCnt", 32'(cnt), 4);
        cyc(1, 5, 32'h55, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("idle_RegWrEn", 32'(wen), 0);
        chk("idle_LastGrant", 32'(lg), 0);
        chk("idle_WriteReg", 32'(wreg), 5);

        // Same Rd from both: B first (A had last grant), then A's value lands last.
        cyc(1, 7, 32'h70, 1, 7, 32'h71, 0, 1, 1);
        cyc(1, 7, 32'h70, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("samerd_WriteData", wdata, 32'h70);
        chk("samerd_ConflictCnt", 32'(cnt), 5);

        // Reset mid-stream while a write is on the port.
        cyc(1, 9, 32'h99, 0, 0, 0, 1, 0, 0);
        chk("t6_pre_RegWrEn", 32'(wen), 1);
        b_v = 1; b_rd = 6; b_d = 32'h66;
        rst_n = 1'b0;
        #1;
        chk("t6_RegWrEn", 32'(wen), 0);
        chk("t6_WriteReg", 32'(wreg), 0);
        chk("t6_WriteData", wdata, 0);
        chk("t6_A_Ready", 32'(a_r), 0);
        chk("t6_B_Ready", 32'(b_r), 0);
        chk("t6_ConflictCnt", 32'(cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 10, 32'hAA, 1, 11, 32'hBB, 1, 0, 1);
        cyc(0, 0, 0, 1, 11, 32'hBB, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_post_ConflictCnt", 32'(cnt), 1);

        // Fixed priority: B wins every conflict, A served when B drops.
        fa_v = 1; fa_rd = 20; fa_d = 32'h200;
        for (int i = 0; i < 3; i++) begin
            fb_v = 1; fb_rd = 5'(i + 1); fb_d = 32'(i);
            @(negedge clk);
            chk("fp_B_Ready", 32'(fb_r), 1);
            chk("fp_A_Ready", 32'(fa_r), 0);
            @(posedge clk); #1;
            chk("fp_WriteReg", 32'(f_wreg), 32'(i + 1));
        end
        fb_v = 0;
        @(negedge clk);
        chk("fp_A_Ready_last", 32'(fa_r), 1);
        chk("fp_B_Ready_last", 32'(fb_r), 0);
        @(posedge clk); #1;
        fa_v = 0;
        chk("fp_A_WriteReg", 32'(f_wreg), 20);
        chk("fp_A_WriteData", f_wdata, 32'h200);
        chk("fp_A_RegWrEn", 32'(f_wen), 1);
        chk("fp_ConflictCnt", 32'(f_cnt), 3);

        // Narrow counter saturates at 3.
        ca_v = 1; cb_v = 1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_c;
            @(posedge clk); #1;
            exp_c = (i < 3) ? 32'(i + 1) : 32'd3;
            chk("c2_ConflictCnt", 32'(c_cnt), exp_c);
        end
        ca_v = 0; cb_v = 0;

        @(posedge clk); #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d writes outstanding expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
